// File: rtl/pre_mem_arbiter.sv
// Two-port arbiter for the pre-processor memory command port. A requester locks the
// port, streams buffer writes, then issues commands one at a time. A watchdog flags stuck commands.
module pre_mem_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_r0_req,
  output logic        o_r0_gnt,
  input  logic        i_r0_go,
  input  logic [3:0]  i_r0_cmd,
  input  logic [31:0] i_r0_addr,
  input  logic        i_r0_wr_buf,
  input  logic [31:0] i_r0_din,
  output logic        o_r0_done,
  input  logic        i_r1_req,
  output logic        o_r1_gnt,
  input  logic        i_r1_go,
  input  logic [3:0]  i_r1_cmd,
  input  logic [31:0] i_r1_addr,
  input  logic        i_r1_wr_buf,
  input  logic [31:0] i_r1_din,
  output logic        o_r1_done,
  output logic        o_pre_req,
  output logic [3:0]  o_pre_cmd,
  output logic [31:0] o_pre_addr,
  output logic        o_pre_wr_buf,
  output logic [31:0] o_pre_din,
  input  logic        i_mem_pre_sel,
  output logic        o_err_timeout,
  input  logic        i_err_clr
);

  typedef enum logic [1:0] {StIdle, StGrant, StIssue, StDone} state_e;

  localparam logic [15:0] WdLast = 16'(TIMEOUT - 32'd1);

  state_e      r_state, w_state_d;
  logic        r_own, w_own_d;
  logic        r_last, w_last_d;
  logic [1:0]  r_gnt, w_gnt_d;
  logic [1:0]  r_done, w_done_d;
  logic        r_pre_req, w_pre_req_d;
  logic [3:0]  r_pre_cmd, w_pre_cmd_d;
  logic [31:0] r_pre_addr, w_pre_addr_d;
  logic [15:0] r_wdog, w_wdog_d;
  logic        r_err, w_err_d;

  logic        w_win;
  logic        w_own_req;
  logic        w_own_go;
  logic [3:0]  w_own_cmd;
  logic [31:0] w_own_addr;

  // On a tie the port that did not hold the lock last time wins.
  assign w_win      = (i_r0_req & i_r1_req) ? ~r_last : i_r1_req;
  assign w_own_req  = r_own ? i_r1_req  : i_r0_req;
  assign w_own_go   = r_own ? i_r1_go   : i_r0_go;
  assign w_own_cmd  = r_own ? i_r1_cmd  : i_r0_cmd;
  assign w_own_addr = r_own ? i_r1_addr : i_r0_addr;

  always_comb begin
    w_state_d    = r_state;
    w_own_d      = r_own;
    w_last_d     = r_last;
    w_gnt_d      = r_gnt;
    w_done_d     = 2'b00;
    w_pre_req_d  = r_pre_req;
    w_pre_cmd_d  = r_pre_cmd;
    w_pre_addr_d = r_pre_addr;
    w_wdog_d     = r_wdog;
    w_err_d      = r_err & ~i_err_clr;
    unique case (r_state)
      StIdle: begin
        if (i_r0_req | i_r1_req) begin
          w_own_d   = w_win;
          w_gnt_d   = w_win ? 2'b10 : 2'b01;
          w_state_d = StGrant;
        end
      end
      StGrant: begin
        if (w_own_go) begin
          w_pre_cmd_d  = w_own_cmd;
          w_pre_addr_d = w_own_addr;
          w_pre_req_d  = 1'b1;
          w_wdog_d     = 16'd0;
          w_state_d    = StIssue;
        end else if (!w_own_req) begin
          w_gnt_d   = 2'b00;
          w_last_d  = r_own;
          w_state_d = StIdle;
        end
      end
      StIssue: begin
        if (i_mem_pre_sel) begin
          w_pre_req_d = 1'b0;
          w_done_d    = r_own ? 2'b10 : 2'b01;
          w_state_d   = StDone;
        end else begin
          // Set beats a coincident clear.
          if (r_wdog == WdLast) w_err_d = 1'b1;
          if (r_wdog != 16'hFFFF) w_wdog_d = r_wdog + 16'd1;
        end
      end
      StDone: begin
        w_state_d = StGrant;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_own      <= 1'b0;
      r_last     <= 1'b1;
      r_gnt      <= 2'b00;
      r_done     <= 2'b00;
      r_pre_req  <= 1'b0;
      r_pre_cmd  <= 4'd0;
      r_pre_addr <= 32'd0;
      r_wdog     <= 16'd0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_own      <= w_own_d;
      r_last     <= w_last_d;
      r_gnt      <= w_gnt_d;
      r_done     <= w_done_d;
      r_pre_req  <= w_pre_req_d;
      r_pre_cmd  <= w_pre_cmd_d;
      r_pre_addr <= w_pre_addr_d;
      r_wdog     <= w_wdog_d;
      r_err      <= w_err_d;
    end
  end

  always_comb begin
    o_pre_wr_buf = 1'b0;
    o_pre_din    = 32'd0;
    if (r_state == StGrant) begin
      o_pre_wr_buf = r_own ? i_r1_wr_buf : i_r0_wr_buf;
      o_pre_din    = r_own ? i_r1_din    : i_r0_din;
    end
  end

  assign o_r0_gnt      = r_gnt[0];
  assign o_r1_gnt      = r_gnt[1];
  assign o_r0_done     = r_done[0];
  assign o_r1_done     = r_done[1];
  assign o_pre_req     = r_pre_req;
  assign o_pre_cmd     = r_pre_cmd;
  assign o_pre_addr    = r_pre_addr;
  assign o_err_timeout = r_err;

endmodule

// File: tb/tb_pre_mem_arbiter.sv
// Directed scenarios followed by randomized lock/command transactions checked against
// a transaction-level model of the arbitration and command handshake.
module tb_pre_mem_arbiter;
  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, go, wr;
  logic [3:0]  cmd [2];
  logic [31:0] addr [2];
  logic [31:0] din [2];
  logic        sel, clr;
  logic        gnt0, gnt1, done0, done1, pre_req, pre_wr, err;
  logic [3:0]  pre_cmd;
  logic [31:0] pre_addr, pre_din;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pre_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_r0_req(req[0]), .o_r0_gnt(gnt0), .i_r0_go(go[0]), .i_r0_cmd(cmd[0]),
    .i_r0_addr(addr[0]), .i_r0_wr_buf(wr[0]), .i_r0_din(din[0]), .o_r0_done(done0),
    .i_r1_req(req[1]), .o_r1_gnt(gnt1), .i_r1_go(go[1]), .i_r1_cmd(cmd[1]),
    .i_r1_addr(addr[1]), .i_r1_wr_buf(wr[1]), .i_r1_din(din[1]), .o_r1_done(done1),
    .o_pre_req(pre_req), .o_pre_cmd(pre_cmd), .o_pre_addr(pre_addr),
    .o_pre_wr_buf(pre_wr), .o_pre_din(pre_din),
    .i_mem_pre_sel(sel), .o_err_timeout(err), .i_err_clr(clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    req = 2'b00; go = 2'b00; wr = 2'b00; sel = 1'b0; clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cmd[i] = 4'd0; addr[i] = 32'd0; din[i] = 32'd0;
    end
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  int          w, nw, p, nb, nc, dly, m_last;
  logic [3:0]  c;
  logic [31:0] a, d;

  initial begin
    clear_in();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_gnt", {gnt1, gnt0}, 2'b00);
    chk("rst_done", {done1, done0}, 2'b00);
    chk("rst_pre_req", pre_req, 1'b0);
    chk("rst_pre_cmd", pre_cmd, 4'd0);
    chk("rst_pre_addr", pre_addr, 32'd0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    tick();

    // Single command with buffer writes
    wr[0] = 1'b1; din[0] = 32'h77;
    #1;
    chk("idle_no_wr", {pre_wr, pre_din}, 33'd0);
    wr[0] = 1'b0; din[0] = 32'd0;
    req[0] = 1'b1;
    tick();
    chk("t1_gnt", {gnt1, gnt0}, 2'b01);
    for (int i = 1; i <= 3; i++) begin
      wr[0] = 1'b1; din[0] = 32'(i * 32'h11);
      #1;
      chk("t1_wr", pre_wr, 1'b1);
      chk("t1_din", pre_din, 32'(i * 32'h11));
      tick();
    end
    wr[0] = 1'b0;
    go[0] = 1'b1; cmd[0] = 4'h2; addr[0] = 32'h0000_1000;
    tick();
    go[0] = 1'b0; cmd[0] = 4'h0; addr[0] = 32'd0;
    chk("t1_pre_req", pre_req, 1'b1);
    chk("t1_cmd", pre_cmd, 4'h2);
    chk("t1_addr", pre_addr, 32'h0000_1000);
    tick();
    tick();
    chk("t1_hold", {pre_req, done0}, 2'b10);
    sel = 1'b1;
    tick();
    sel = 1'b0;
    chk("t1_done", {pre_req, done0}, 2'b01);
    chk("t1_cmd_keep", pre_cmd, 4'h2);
    tick();
    chk("t1_done_pulse", done0, 1'b0);
    req[0] = 1'b0;
    tick();
    chk("t1_release", gnt0, 1'b0);

    // Tie and round-robin
    do_reset();
    req = 2'b11;
    tick();
    chk("t2_tie", {gnt1, gnt0}, 2'b01);
    req[0] = 1'b0;
    tick();
    chk("t2_rel", {gnt1, gnt0}, 2'b00);
    tick();
    chk("t2_rr1", {gnt1, gnt0}, 2'b10);
    req = 2'b01;
    tick();
    req = 2'b11;
    tick();
    chk("t2_rr0", {gnt1, gnt0}, 2'b01);
    req = 2'b00;
    tick();
    tick();

    // Non-owner isolation
    do_reset();
    req[0] = 1'b1;
    tick();
    wr[1] = 1'b1; din[1] = 32'hDEAD; go[1] = 1'b1; cmd[1] = 4'hF; addr[1] = 32'hBAD;
    #1;
    chk("t3_iso_wr", {pre_wr, pre_din}, 33'd0);
    wr[0] = 1'b1; din[0] = 32'h55;
    #1;
    chk("t3_own_din", {pre_wr, pre_din}, {1'b1, 32'h55});
    tick();
    chk("t3_no_req", pre_req, 1'b0);
    chk("t3_gnt", {gnt1, gnt0}, 2'b01);
    clear_in();
    req[0] = 1'b1;

    // Release during ISSUE
    go[0] = 1'b1; cmd[0] = 4'h5; addr[0] = 32'h40;
    tick();
    go[0] = 1'b0;
    req[0] = 1'b0;
    tick();
    chk("t4_hold", {pre_req, gnt0}, 2'b11);
    tick();
    chk("t4_hold2", pre_req, 1'b1);
    sel = 1'b1;
    tick();
    sel = 1'b0;
    chk("t4_done", {pre_req, done0, gnt0}, 3'b011);
    tick();
    chk("t4_back", {done0, gnt0}, 2'b01);
    tick();
    chk("t4_rel", gnt0, 1'b0);

    // Watchdog
    req[0] = 1'b1;
    tick();
    go[0] = 1'b1; cmd[0] = 4'h7; addr[0] = 32'h80;
    tick();
    go[0] = 1'b0;
    repeat (TO - 1) tick();
    chk("t5_pre_err", err, 1'b0);
    tick();
    chk("t5_err", {err, pre_req}, 2'b11);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_clr", {err, pre_req}, 2'b01);
    sel = 1'b1;
    tick();
    sel = 1'b0;
    chk("t5_done", {done0, pre_req, err}, 3'b100);
    tick();
    go[0] = 1'b1;
    tick();
    go[0] = 1'b0;
    clr = 1'b1;
    repeat (TO - 1) tick();
    chk("t5_clr_hold", err, 1'b0);
    tick();
    chk("t5_set_wins", err, 1'b1);
    tick();
    clr = 1'b0;
    chk("t5_clr2", err, 1'b0);
    sel = 1'b1;
    tick();
    sel = 1'b0;
    chk("t5_done2", done0, 1'b1);
    tick();

    // Reset mid-command
    go[0] = 1'b1; cmd[0] = 4'h9; addr[0] = 32'hC0;
    tick();
    go[0] = 1'b0;
    chk("t6_req", pre_req, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_async", {pre_req, gnt0, gnt1, done0, done1, err}, 6'd0);
    chk("t6_cmd", {pre_cmd, pre_addr}, 36'd0);
    #1;
    rst = 1'b0;
    req = 2'b11;
    tick();
    chk("t6_tie", {gnt1, gnt0}, 2'b01);
    clear_in();
    tick();

    // Randomized transactions
    m_last = 0;
    for (int it = 0; it < 40; it++) begin
      p = int'($urandom_range(1, 3));
      req = 2'(p);
      w = (p == 3) ? 1 - m_last : (p == 2 ? 1 : 0);
      nw = 1 - w;
      tick();
      chk("r_gnt", {gnt1, gnt0}, (w == 1) ? 2'b10 : 2'b01);
      nb = int'($urandom_range(0, 3));
      for (int b = 0; b < nb; b++) begin
        d = $urandom;
        wr[w] = 1'b1; din[w] = d;
        wr[nw] = 1'($urandom); din[nw] = $urandom;
        #1;
        chk("r_din", {pre_wr, pre_din}, {1'b1, d});
        tick();
      end
      wr = 2'b00;
      nc = int'($urandom_range(0, 2));
      for (int k = 0; k < nc; k++) begin
        c = 4'($urandom); a = $urandom;
        go[w] = 1'b1; cmd[w] = c; addr[w] = a;
        go[nw] = 1'($urandom); cmd[nw] = ~c; addr[nw] = ~a;
        tick();
        go = 2'b00; cmd[w] = 4'($urandom); addr[w] = $urandom;
        chk("r_issue", {pre_req, pre_cmd, pre_addr}, {1'b1, c, a});
        dly = int'($urandom_range(0, 5));
        for (int j = 0; j < dly; j++) begin
          go[w] = 1'($urandom);
          tick();
          go = 2'b00;
          chk("r_wait", {pre_req, done1, done0, pre_cmd, pre_addr}, {3'b100, c, a});
        end
        sel = 1'b1;
        tick();
        sel = 1'b0;
        chk("r_done", {pre_req, done1, done0}, (w == 1) ? 3'b010 : 3'b001);
        go[w] = 1'($urandom);
        tick();
        go = 2'b00;
        chk("r_post", {pre_req, done1, done0, err}, 4'd0);
      end
      req[w] = 1'b0;
      tick();
      chk("r_rel", {gnt1, gnt0}, 2'b00);
      m_last = w;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
